// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, start-glitch
// rejection, framing-error/break handling and a valid/ready byte output with overrun pulse.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV  = CLK_FREQ_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLK_FREQ_HZ/BAUD must be at least 4");
  end

  logic          sync1;
  logic          rxd_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A byte loaded later in this block on the same edge overrides this clear.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == DIV_M1) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == DIV_M1) begin
            cnt <= '0;
            if (rxd_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              overrun  <= rx_valid && !rx_ready;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BRK: begin
          if (rxd_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit-serially and compared against
// a queue/counter reference of what the line protocol says must come out.
module tb_uart_rx;

  localparam int DIV  = 25000000 / 115200;
  localparam int HALF = DIV / 2;
  // two synchroniser flops, one detect edge, then the stop-sample offset
  localparam int LATENCY = 2 + 1 + HALF + 9 * DIV;

  logic       clk;
  logic       resetn;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  int unsigned busy_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  got_q[$];

  uart_rx dut (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc <= cyc;
    prev_valid <= rx_valid;
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #5;
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    rxd = v;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    hold(stop, DIV);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: valid=%b fe=%b ov=%b busy=%b data=%h required 0/0/0/0/00",
               rx_valid, frame_err, overrun, busy, rx_data);
    end
    resetn = 1'b1;
    step(5);
    checks++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b busy=%b required 0/0", rx_valid, busy);
    end
  endtask

  task automatic test_basic();
    int unsigned base;
    base = got_q.size();
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      errors++;
      $display("FAIL basic_byte: valid=%b data=%h required 1/55", rx_valid, rx_data);
    end
    checks++;
    if (rise_cyc - fall_cyc !== LATENCY) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required %0d", rise_cyc - fall_cyc, LATENCY);
    end
    consume();
    checks++;
    if (rx_valid !== 1'b0 || got_q.size() !== base + 1) begin
      errors++;
      $display("FAIL basic_handshake: valid=%b accepted=%0d required 0/1", rx_valid, got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== 8'h55) begin
        errors++;
        $display("FAIL basic_accepted: got %h required 55", got_q[base]);
      end
    end
    step(10);
  endtask

  task automatic test_glitch();
    int unsigned fe0, b0;
    fe0 = fe_cnt;
    b0  = busy_cnt;
    hold(1'b0, 50);
    hold(1'b1, 400);
    checks++;
    if (busy_cnt - b0 !== HALF) begin
      errors++;
      $display("FAIL glitch_busy: busy cycles %0d required %0d", busy_cnt - b0, HALF);
    end
    checks++;
    if (fe_cnt !== fe0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_output: fe=%0d valid=%b required 0/0", fe_cnt - fe0, rx_valid);
    end
  endtask

  task automatic test_frame_err();
    int unsigned fe0;
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0);
    hold(1'b0, 100 * DIV);
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      errors++;
      $display("FAIL break_single_fe: fe cycles %0d required 1", fe_cnt - fe0);
    end
    checks++;
    if (rx_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL break_hold: valid=%b busy=%b required 0/1", rx_valid, busy);
    end
    hold(1'b1, 10);
    checks++;
    if (busy !== 1'b0 || fe_cnt - fe0 !== 1) begin
      errors++;
      $display("FAIL break_release: busy=%b fe=%0d required 0/1", busy, fe_cnt - fe0);
    end
  endtask

  task automatic test_overrun();
    int unsigned ov0, base;
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    checks++;
    if (ov_cnt - ov0 !== 1 || rx_valid !== 1'b1 || rx_data !== 8'h34) begin
      errors++;
      $display("FAIL overrun_pulse: ov=%0d valid=%b data=%h required 1/1/34",
               ov_cnt - ov0, rx_valid, rx_data);
    end
    consume();
    ov0  = ov_cnt;
    base = got_q.size();
    rx_ready = 1'b1;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    hold(1'b1, 4);
    rx_ready = 1'b0;
    checks++;
    if (ov_cnt !== ov0 || got_q.size() !== base + 2) begin
      errors++;
      $display("FAIL ready_held: ov=%0d accepted=%0d required 0/2", ov_cnt - ov0, got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base] !== 8'h12 || got_q[base+1] !== 8'h34) begin
        errors++;
        $display("FAIL ready_held_order: got %h %h required 12 34", got_q[base], got_q[base+1]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int unsigned fe0;
    fe0 = fe_cnt;
    rx_ready = 1'b0;
    hold(1'b0, DIV);
    hold(1'b1, 5 * DIV);
    resetn = 1'b0;
    hold(1'b1, 3);
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b valid=%b required 0/0", busy, rx_valid);
    end
    resetn = 1'b1;
    hold(1'b1, 3 * DIV);
    checks++;
    if (rx_valid !== 1'b0 || fe_cnt !== fe0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_output: valid=%b fe=%0d busy=%b required 0/0/0",
               rx_valid, fe_cnt - fe0, busy);
    end
    send_frame(8'h0F, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h0F || rise_cyc - fall_cyc !== LATENCY) begin
      errors++;
      $display("FAIL abort_next_frame: valid=%b data=%h lat=%0d required 1/0f/%0d",
               rx_valid, rx_data, rise_cyc - fall_cyc, LATENCY);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    int unsigned fe0, base;
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h80;
    fe0  = fe_cnt;
    base = got_q.size();
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    hold(1'b1, 4);
    rx_ready = 1'b0;
    checks++;
    if (got_q.size() !== base + 3 || fe_cnt !== fe0) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d fe=%0d required 3/0", got_q.size() - base, fe_cnt - fe0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[base+i] !== exp_b[i]) begin
          errors++;
          $display("FAIL b2b_byte%0d: got %h required %h", i, got_q[base+i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_b[6];
    logic [7:0] last;
    int unsigned base, ov0, k;
    base = got_q.size();
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_b[i] = 8'($urandom);
      send_frame(exp_b[i], 1'b1);
      hold(1'b1, $urandom_range(0, 300));
    end
    hold(1'b1, 4);
    rx_ready = 1'b0;
    checks++;
    if (got_q.size() !== base + 6) begin
      errors++;
      $display("FAIL rand_count: accepted=%0d required 6", got_q.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[base+i] !== exp_b[i]) begin
          errors++;
          $display("FAIL rand_byte%0d: got %h required %h", i, got_q[base+i], exp_b[i]);
        end
      end
    end
    // Unconsumed burst: every frame after the first overwrites a pending byte.
    k    = $urandom_range(1, 3);
    ov0  = ov_cnt;
    last = 8'h00;
    for (int i = 0; i < int'(k); i++) begin
      last = 8'($urandom);
      send_frame(last, 1'b1);
      hold(1'b1, $urandom_range(0, 100));
    end
    checks++;
    if (ov_cnt - ov0 !== k - 1 || rx_valid !== 1'b1 || rx_data !== last) begin
      errors++;
      $display("FAIL rand_burst: ov=%0d valid=%b data=%h required %0d/1/%h",
               ov_cnt - ov0, rx_valid, rx_data, k - 1, last);
    end
    consume();
  endtask

  initial begin
    resetn   = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    step(3);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
